atm_host_sequencer: RTL
=======================

ATM_HOST_SEQUENCER -- requirements
Module: atm_host_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4: cycles each request is held on the ATM inputs before the result is sampled.
REQ-002 The block SHALL have parameter LOCK_LIMIT, default 3: consecutive ATM failures that lock an account.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a host transaction request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the sequencer accepts a request this cycle.
REQ-007 The block SHALL have port req_op, input, 3 bits: operation code (3 = balance, 4 = withdraw, 5 = deposit; others passed through).
REQ-008 The block SHALL have port req_acc, input, 4 bits: account number; valid range 1..10.
REQ-009 The block SHALL have port req_pin, input, 16 bits: account PIN.
REQ-010 The block SHALL have port req_newpin, input, 16 bits: replacement PIN.
REQ-011 The block SHALL have port req_amount, input, 32 bits: transaction amount.
REQ-012 The block SHALL have port req_lang, input, 1 bit: language select.
REQ-013 The block SHALL have ports atm_operation (3 bits), atm_acc_num (4), atm_pin (16), atm_newpin (16), atm_amount (32) and atm_language (1), all outputs: registered drive to the ATM responder.
REQ-014 The block SHALL have ports atm_balance (32 bits) and atm_success (1 bit), both inputs: the ATM responder's result.
REQ-015 The block SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-016 The block SHALL have port rsp_ready, input, 1 bit: the host consumes the response.
REQ-017 The block SHALL have port rsp_code, output, 2 bits: 0 = OK, 1 = denied by ATM, 2 = account locked, 3 = bad account.
REQ-018 The block SHALL have ports rsp_balance (32 bits) and rsp_success (1 bit), both outputs: the captured ATM result.

Function
REQ-019 The FSM SHALL have states IDLE, HOLD and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 On a req_valid && req_ready edge, all req_* fields SHALL be registered.
REQ-021 If the accepted req_acc is 0 or greater than 10, the FSM SHALL go to RESP with rsp_code = 3, rsp_success = 0 and rsp_balance = 0, and rsp_valid SHALL be high in the cycle after accept.
REQ-022 Else, if the account's fail counter equals LOCK_LIMIT, the same local rejection SHALL occur with rsp_code = 2.
REQ-023 In both local-rejection cases no ATM drive SHALL occur: atm_operation stays 0.
REQ-024 Otherwise the FSM SHALL go to HOLD, and the atm_* outputs SHALL carry the request from the cycle after accept.
REQ-025 The atm_* outputs SHALL be held stable for exactly HOLD_CYCLES rising edges.
REQ-026 On the final HOLD edge, atm_balance SHALL be captured into rsp_balance and atm_success into rsp_success.
REQ-027 On that same edge, rsp_code SHALL be set to 0 if atm_success = 1, else 1; the FSM SHALL enter RESP and all atm_* outputs SHALL return to 0.
REQ-028 Fail counters: one 2-bit counter per account 1..10.
REQ-029 A fail counter SHALL be cleared on an ATM success and incremented on an ATM failure, saturating at LOCK_LIMIT.
REQ-030 A fail counter SHALL NOT change on local rejections.
REQ-031 Locks SHALL be cleared only by reset.
REQ-032 In RESP, rsp_valid = 1 and all rsp_* outputs SHALL remain stable until rsp_ready = 1.
REQ-033 The handshake edge SHALL return the FSM to IDLE and drop rsp_valid; a new request can be accepted no earlier than the following edge.
REQ-034 req_* changes while not in IDLE SHALL be ignored.
REQ-035 Accept-to-rsp_valid latency SHALL be HOLD_CYCLES + 1 edges for issued requests, and 1 edge for local rejections.

Reset
REQ-036 While rst = 0, the FSM SHALL be IDLE and req_ready = 1 once rst releases.
REQ-037 While rst = 0, rsp_valid, rsp_code, rsp_balance, rsp_success, all atm_* outputs and all fail counters SHALL be 0.
REQ-038 Reset asserted mid-HOLD or mid-RESP SHALL abort immediately, with no response and no counter update.

Verification
REQ-039 Bench: op 3, acc 1, pin 1234; ATM returns success = 1, balance 5000 -> atm_* stable 4 cycles; rsp_valid 5 edges after accept; code 0, balance 5000.
REQ-040 Bench: op 5, acc 2, pin 9999; success = 0, repeated three times -> codes 1,1,1; fourth request -> code 2 after 1 cycle, atm_operation stays 0; acc 3 still issues normally.
REQ-041 Bench: acc 1 fails twice then succeeds, then fails twice more -> all responses issued, never code 2.
REQ-042 Bench: acc 11 and acc 0 -> code 3, rsp_valid 1 edge after accept, no ATM drive.
REQ-043 Bench: rsp_ready held low 10 cycles -> rsp_* constant, req_ready = 0, req_valid ignored.
REQ-044 Bench: rst = 0 at HOLD cycle 2 -> all outputs 0 asynchronously; after release, a new acc 1 request completes normally with counters cleared.

Source files
------------

// File: rtl/atm_host_sequencer.sv
// Host-side sequencer for an ATM responder: it accepts one request, holds it on the ATM bus
// for a fixed number of cycles, captures the result and tracks per-account failure locks.
module atm_host_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int LOCK_LIMIT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_acc,
    input  logic [15:0] req_pin,
    input  logic [15:0] req_newpin,
    input  logic [31:0] req_amount,
    input  logic        req_lang,
    output logic [2:0]  atm_operation,
    output logic [3:0]  atm_acc_num,
    output logic [15:0] atm_pin,
    output logic [15:0] atm_newpin,
    output logic [31:0] atm_amount,
    output logic        atm_language,
    input  logic [31:0] atm_balance,
    input  logic        atm_success,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_code,
    output logic [31:0] rsp_balance,
    output logic        rsp_success
);

    localparam int          CW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [1:0]  LOCK    = 2'(LOCK_LIMIT);

    typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [3:0]     r_acc;
    logic [1:0]     r_fail [1:10];

    logic           w_acc_ok;
    logic [1:0]     w_fail_cnt;
    logic [1:0]     w_cur_fail;

    assign w_acc_ok   = (req_acc != 4'd0) && (req_acc <= 4'd10);
    assign w_fail_cnt = w_acc_ok ? r_fail[req_acc] : 2'd0;
    assign w_cur_fail = r_fail[r_acc];

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_acc         <= '0;
            atm_operation <= '0;
            atm_acc_num   <= '0;
            atm_pin       <= '0;
            atm_newpin    <= '0;
            atm_amount    <= '0;
            atm_language  <= 1'b0;
            rsp_code      <= '0;
            rsp_balance   <= '0;
            rsp_success   <= 1'b0;
            for (int i = 1; i <= 10; i++) r_fail[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_acc <= req_acc;
                        if (!w_acc_ok || w_fail_cnt == LOCK) begin
                            // Local rejection: answer immediately, ATM bus stays quiet.
                            r_state     <= RESP;
                            rsp_code    <= w_acc_ok ? 2'd2 : 2'd3;
                            rsp_balance <= '0;
                            rsp_success <= 1'b0;
                        end else begin
                            r_state       <= HOLD;
                            r_cnt         <= '0;
                            atm_operation <= req_op;
                            atm_acc_num   <= req_acc;
                            atm_pin       <= req_pin;
                            atm_newpin    <= req_newpin;
                            atm_amount    <= req_amount;
                            atm_language  <= req_lang;
                        end
                    end
                end
                HOLD: begin
                    if (r_cnt == LAST) begin
                        r_state       <= RESP;
                        rsp_balance   <= atm_balance;
                        rsp_success   <= atm_success;
                        rsp_code      <= atm_success ? 2'd0 : 2'd1;
                        atm_operation <= '0;
                        atm_acc_num   <= '0;
                        atm_pin       <= '0;
                        atm_newpin    <= '0;
                        atm_amount    <= '0;
                        atm_language  <= 1'b0;
                        if (atm_success)
                            r_fail[r_acc] <= '0;
                        else if (w_cur_fail != LOCK)
                            r_fail[r_acc] <= w_cur_fail + 2'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
